// File: rtl/sysarr_pkg.sv
// Shared constants and helpers for the systolic array datapath.
// No logic; imported by the array-side blocks.
// Constants only, so there is no backpressure behaviour.
package sysarr_pkg;

    localparam int MATRIX_SIZE    = 128;
    localparam int PARTIAL_SUM_BW = 24;
    localparam int DATA_BW        = 8;
    localparam int WEIGHT_BW      = 8;

    // Width of an occupancy count for a FIFO of 'depth' entries (0..depth inclusive).
    function automatic int lvl_bw(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sysarr_sync_fifo.sv
// Synchronous FIFO with a registered read pointer and an extra pointer bit for full/empty.
// Latency: a push is visible at the head on the next cycle; the head is read combinationally.
// Backpressure: none internally; the caller must not push when full unless it also pops.
module sysarr_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                                    clk,
    input  logic                                    rstn,
    input  logic                                    push,
    input  logic                                    pop,
    input  logic [WIDTH-1:0]                        wr_dat,
    output logic [WIDTH-1:0]                        rd_dat,
    output logic                                    full,
    output logic                                    empty,
    output logic [sysarr_pkg::lvl_bw(DEPTH)-1:0]    level
);
    import sysarr_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // When full and popping, the write lands in the slot being vacated this cycle.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_dat;
    end

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level  = wr_ptr - rd_ptr;
    assign rd_dat = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/sysarr_result_deskew.sv
// Realigns row-skewed systolic results into one vector per wavefront; SYSARR_RESULT_RELU_EN clamps negative lanes to 0.
// Latency: in_valid at cycle t gives out_valid at t+MATRIX_SIZE when the FIFO is empty.
// Backpressure: out_ready holds the FIFO head; the array cannot stall, so a full FIFO drops and sets overflow.
module sysarr_result_deskew #(
    parameter int MATRIX_SIZE    = sysarr_pkg::MATRIX_SIZE,
    parameter int PARTIAL_SUM_BW = sysarr_pkg::PARTIAL_SUM_BW,
    parameter int FIFO_DEPTH     = 4,
    parameter int CNT_BW         = 16
) (
    input  logic                                         clk,
    input  logic                                         rstn,
    input  logic                                         in_valid,
    input  logic [MATRIX_SIZE*PARTIAL_SUM_BW-1:0]        ROW_RESULTS,
    input  logic                                         clr_ovf,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [MATRIX_SIZE*PARTIAL_SUM_BW-1:0]        OUT_VEC,
    output logic                                         overflow,
    output logic [sysarr_pkg::lvl_bw(FIFO_DEPTH)-1:0]    fifo_level,
    output logic [CNT_BW-1:0]                            vec_count
);
    import sysarr_pkg::*;

    localparam int PSB = PARTIAL_SUM_BW;
    localparam int VW  = MATRIX_SIZE * PSB;

    logic [MATRIX_SIZE-2:0] vld_pipe;
    logic                   aligned_vld;
    logic [VW-1:0]          fifo_wr_dat;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   push;
    logic                   pop;
    logic                   drop;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= in_valid;
            for (int i = 1; i < MATRIX_SIZE - 1; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    assign aligned_vld = vld_pipe[MATRIX_SIZE-2];

    // Row r arrives r cycles late, so it is held back by the remaining MATRIX_SIZE-1-r cycles.
    for (genvar r = 0; r < MATRIX_SIZE; r++) begin : g_lane
        localparam int DLY = MATRIX_SIZE - 1 - r;
        logic [PSB-1:0] lane;

        if (DLY == 0) begin : g_thru
            assign lane = ROW_RESULTS[r*PSB +: PSB];
        end else begin : g_dly
            logic [PSB-1:0] sr [DLY];
            always_ff @(posedge clk) begin
                sr[0] <= ROW_RESULTS[r*PSB +: PSB];
                for (int i = 1; i < DLY; i++) sr[i] <= sr[i-1];
            end
            assign lane = sr[DLY-1];
        end

`ifdef SYSARR_RESULT_RELU_EN
        assign fifo_wr_dat[r*PSB +: PSB] = lane[PSB-1] ? '0 : lane;
`else
        assign fifo_wr_dat[r*PSB +: PSB] = lane;
`endif
    end

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign push      = aligned_vld && (!fifo_full || pop);
    assign drop      = aligned_vld && fifo_full && !pop;

    sysarr_sync_fifo #(
        .WIDTH (VW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rstn   (rstn),
        .push   (push),
        .pop    (pop),
        .wr_dat (fifo_wr_dat),
        .rd_dat (OUT_VEC),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (fifo_level)
    );

    // A drop in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overflow  <= 1'b0;
            vec_count <= '0;
        end else begin
            if (drop)         overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
            if (pop) vec_count <= vec_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_sysarr_result_deskew.sv
// Randomised scoreboard bench for sysarr_result_deskew at MATRIX_SIZE=4, FIFO_DEPTH=2.
// A queue-level reference model predicts deliveries, occupancy, overflow and the wrapping counter.
module tb_sysarr_result_deskew;

    localparam int M      = 4;
    localparam int PSB    = 24;
    localparam int DEPTH  = 2;
    localparam int CNT_BW = 4;
    localparam int VW     = M * PSB;
    localparam int LBW    = $clog2(DEPTH) + 1;
    localparam int NCYC   = 4096;

    typedef logic [VW-1:0] vec_t;

    logic              clk = 1'b0;
    logic              rstn;
    logic              in_valid;
    logic [VW-1:0]     ROW_RESULTS;
    logic              clr_ovf;
    logic              out_valid;
    logic              out_ready;
    logic [VW-1:0]     OUT_VEC;
    logic              overflow;
    logic [LBW-1:0]    fifo_level;
    logic [CNT_BW-1:0] vec_count;

    always #5 clk = ~clk;

    sysarr_result_deskew #(
        .MATRIX_SIZE    (M),
        .PARTIAL_SUM_BW (PSB),
        .FIFO_DEPTH     (DEPTH),
        .CNT_BW         (CNT_BW)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .in_valid    (in_valid),
        .ROW_RESULTS (ROW_RESULTS),
        .clr_ovf     (clr_ovf),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .OUT_VEC     (OUT_VEC),
        .overflow    (overflow),
        .fifo_level  (fifo_level),
        .vec_count   (vec_count)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    bit   sched_vld [NCYC];
    vec_t sched_vec [NCYC];
    vec_t exp_q [$];
    int   m_lvl = 0;
    bit   m_ovf = 1'b0;
    int   m_cnt = 0;

    function automatic vec_t expect_vec(input vec_t v);
        vec_t e;
        e = v;
`ifdef SYSARR_RESULT_RELU_EN
        for (int l = 0; l < M; l++)
            if (e[l*PSB + PSB - 1]) e[l*PSB +: PSB] = '0;
`endif
        return e;
    endfunction

    function automatic vec_t rvec();
        vec_t v;
        for (int l = 0; l < M; l++) v[l*PSB +: PSB] = PSB'($urandom);
        return v;
    endfunction

    task automatic chk(input string name, input vec_t act, input vec_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
        end
    endtask

    // Reference model: a wavefront issued at cycle t reaches the FIFO at the end of cycle t+M-1.
    always @(posedge clk) begin
        bit pop;
        bit drop;
        if (rstn === 1'b1) begin
            pop  = (m_lvl > 0) && out_ready;
            drop = 1'b0;
            if (cyc >= M - 1 && sched_vld[cyc-(M-1)]) begin
                if (m_lvl < DEPTH || pop) begin
                    exp_q.push_back(expect_vec(sched_vec[cyc-(M-1)]));
                    m_lvl++;
                end else begin
                    drop = 1'b1;
                end
            end
            if (drop)         m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
            if (pop) begin
                m_lvl--;
                m_cnt = (m_cnt + 1) % (1 << CNT_BW);
            end
        end
        cyc++;
    end

    // Reset discards everything in flight, including wavefronts not yet aligned.
    always @(negedge rstn) begin
        m_lvl = 0;
        m_ovf = 1'b0;
        m_cnt = 0;
        exp_q.delete();
        for (int i = 0; i < NCYC; i++) sched_vld[i] = 1'b0;
    end

    // Monitor: compares the FIFO head against the scoreboard whenever a vector is presented.
    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            chk("out_valid",  vec_t'(out_valid),  vec_t'(m_lvl != 0));
            chk("fifo_level", vec_t'(fifo_level), vec_t'(m_lvl));
            chk("overflow",   vec_t'(overflow),   vec_t'(m_ovf));
            chk("vec_count",  vec_t'(vec_count),  vec_t'(m_cnt));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_vec at cycle %0d: got %h, want no output", cyc, OUT_VEC);
                end else begin
                    chk("out_vec", OUT_VEC, exp_q[0]);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // Drives one cycle: lane r carries the wavefront issued r cycles earlier, or garbage.
    task automatic drive(input bit iv, input bit rdy, input bit clr, input vec_t v);
        in_valid  = iv;
        out_ready = rdy;
        clr_ovf   = clr;
        if (iv) begin
            sched_vld[cyc] = 1'b1;
            sched_vec[cyc] = v;
        end
        for (int r = 0; r < M; r++) begin
            if (cyc >= r && sched_vld[cyc-r]) ROW_RESULTS[r*PSB +: PSB] = sched_vec[cyc-r][r*PSB +: PSB];
            else                              ROW_RESULTS[r*PSB +: PSB] = PSB'($urandom);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit rdy, input int n);
        for (int i = 0; i < n; i++) drive(1'b0, rdy, 1'b0, '0);
    endtask

    initial begin
        vec_t v;
        rstn        = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        clr_ovf     = 1'b0;
        ROW_RESULTS = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid",  vec_t'(out_valid),  '0);
        chk("rst_out_vec",    OUT_VEC,            '0);
        chk("rst_fifo_level", vec_t'(fifo_level), '0);
        chk("rst_overflow",   vec_t'(overflow),   '0);
        chk("rst_vec_count",  vec_t'(vec_count),  '0);
        rstn = 1'b1;

        // Single wavefront: lanes {4,3,2,1}
        v = '0;
        for (int r = 0; r < M; r++) v[r*PSB +: PSB] = PSB'(r + 1);
        drive(1'b1, 1'b1, 1'b0, v);
        idle(1'b1, 8);
        chk("t1_vec_count", vec_t'(vec_count), vec_t'(1));

        // Back-to-back streaming
        repeat (3) drive(1'b1, 1'b1, 1'b0, rvec());
        idle(1'b1, 8);
        chk("t2_vec_count", vec_t'(vec_count), vec_t'(4));

        // Backpressure and overflow, then drain and clear
        repeat (3) drive(1'b1, 1'b0, 1'b0, rvec());
        idle(1'b0, 6);
        chk("t3_level",    vec_t'(fifo_level), vec_t'(2));
        chk("t3_overflow", vec_t'(overflow),   vec_t'(1));
        idle(1'b1, 4);
        drive(1'b0, 1'b1, 1'b1, '0);
        chk("t3_clr_ovf",   vec_t'(overflow),  '0);
        chk("t3_vec_count", vec_t'(vec_count), vec_t'(6));

        // Full FIFO with a pop in the cycle the third vector aligns
        repeat (3) drive(1'b1, 1'b0, 1'b0, rvec());
        idle(1'b0, 2);
        drive(1'b0, 1'b1, 1'b0, '0);
        chk("t4_level",    vec_t'(fifo_level), vec_t'(2));
        chk("t4_overflow", vec_t'(overflow),   '0);
        idle(1'b1, 6);
        chk("t4_vec_count", vec_t'(vec_count), vec_t'(9));

        // Asynchronous reset in the middle of a wavefront
        drive(1'b1, 1'b1, 1'b0, rvec());
        drive(1'b0, 1'b1, 1'b0, '0);
        #2;
        rstn = 1'b0;
        #1;
        chk("t5_out_valid",  vec_t'(out_valid),  '0);
        chk("t5_out_vec",    OUT_VEC,            '0);
        chk("t5_fifo_level", vec_t'(fifo_level), '0);
        chk("t5_overflow",   vec_t'(overflow),   '0);
        chk("t5_vec_count",  vec_t'(vec_count),  '0);
        #3;
        rstn = 1'b1;
        idle(1'b1, 10);

        // Negative lane
        v = '0;
        for (int r = 0; r < M; r++) v[r*PSB +: PSB] = PSB'(10 * (r + 1));
        v[1*PSB +: PSB] = 24'hFFFFFB;
        drive(1'b1, 1'b1, 1'b0, v);
        idle(1'b1, 8);

        // Random traffic: counter wraps, overflow and clears interleave
        repeat (500)
            drive(bit'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, rvec());
        idle(1'b1, 12);
        chk("drain_empty", vec_t'(exp_q.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
